// File: rtl/enable_monitor_pkg.sv
// Shared definitions for the enable sequence monitor: state encoding,
// the expected enable pattern of each state and the timeout error code.
package enable_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_S1        = 3'd1,
        ST_S2        = 3'd2,
        ST_S3        = 3'd3,
        ST_S4        = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [3:0] PAT_IDLE = 4'b0000;
    localparam logic [3:0] PAT_S1   = 4'b1111;
    localparam logic [3:0] PAT_S2   = 4'b1110;
    localparam logic [3:0] PAT_S3   = 4'b1100;
    localparam logic [3:0] PAT_S4   = 4'b1000;

    localparam logic [2:0] ERR_TIMEOUT = 3'b111;

    // Enable pattern that a state expects to keep seeing.
    function automatic logic [3:0] state_pattern(input state_t s);
        logic [3:0] p;
        p = PAT_IDLE;
        case (s)
            ST_S1:   p = PAT_S1;
            ST_S2:   p = PAT_S2;
            ST_S3:   p = PAT_S3;
            ST_S4:   p = PAT_S4;
            default: p = PAT_IDLE;
        endcase
        return p;
    endfunction

    // Successor along the legal power-up sequence.
    function automatic state_t seq_next(input state_t s);
        state_t n;
        n = ST_IDLE;
        case (s)
            ST_IDLE: n = ST_S1;
            ST_S1:   n = ST_S2;
            ST_S2:   n = ST_S3;
            ST_S3:   n = ST_S4;
            default: n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/enable_monitor_sync_filter.sv
// Two-flop synchronizer per bit followed by a stability filter: a new
// value is accepted only after it has been seen unchanged for STABLE_CYC
// consecutive cycles. acc_new pulses for one cycle when acc changes.
module sync_filter #(
    parameter int W          = 4,
    parameter int STABLE_CYC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] acc,
    output logic         acc_new
);

    localparam logic [3:0] STAB = 4'(STABLE_CYC);

    logic [W-1:0] sync_p0;
    logic [W-1:0] sync_p1;
    logic [W-1:0] cand;
    logic [3:0]   cnt;
    logic [3:0]   cnt_n;

    // Synchronizer chain: only sync_p1 is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
        end
    end

    // Run length of the current synchronized value, saturating at STAB.
    always_comb begin
        cnt_n = 4'd1;
        if (sync_p1 == cand) begin
            cnt_n = (cnt == STAB) ? cnt : cnt + 4'd1;
        end
    end

    // Accept a value once its run length first reaches STAB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand    <= '0;
            cnt     <= '0;
            acc     <= '0;
            acc_new <= 1'b0;
        end else begin
            cand    <= sync_p1;
            cnt     <= cnt_n;
            acc_new <= 1'b0;
            if (cnt_n == STAB && sync_p1 != acc) begin
                acc     <= sync_p1;
                acc_new <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/enable_monitor.sv
// Watches the four regulator enables and checks they follow the legal
// power-up/power-down order, counting good sequences and latching the
// first error (bad pattern or stall) until cleared.
module enable_monitor
    import enable_monitor_pkg::*;
#(
    parameter int STABLE_CYC = 2,
    parameter int TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ena_in,
    input  logic       clr,
    output logic       seq_done,
    output logic [3:0] ok_count,
    output logic       err,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [3:0] pat;
    logic       pat_new;
    state_t     state;
    state_t     state_n;
    logic [7:0] tmo_cnt;
    logic       done_n;
    logic       err_evt;
    logic [2:0] err_val;

    sync_filter #(
        .W          (4),
        .STABLE_CYC (STABLE_CYC)
    ) u_sync_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (ena_in),
        .acc     (pat),
        .acc_new (pat_new)
    );

    // Next-state decode: advance, stay, or flag a pattern/timeout error.
    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        err_evt = 1'b0;
        err_val = state;
        case (state)
            ST_IDLE: begin
                if (pat_new) begin
                    if (pat == PAT_S1) begin
                        state_n = ST_S1;
                    end else if (pat != PAT_IDLE) begin
                        err_evt = 1'b1;
                        state_n = ST_WAIT_IDLE;
                    end
                end
            end
            ST_S1, ST_S2, ST_S3, ST_S4: begin
                if (pat_new) begin
                    if (pat == state_pattern(state)) begin
                        state_n = state;
                    end else if (pat == state_pattern(seq_next(state))) begin
                        state_n = seq_next(state);
                        done_n  = (state == ST_S4);
                    end else begin
                        err_evt = 1'b1;
                        state_n = ST_WAIT_IDLE;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    err_evt = 1'b1;
                    err_val = ERR_TIMEOUT;
                    state_n = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (pat_new && pat == PAT_IDLE) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register and stall counter (cleared on any state change).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_n;
            if (state_n != state) begin
                tmo_cnt <= '0;
            end else if (state inside {ST_S1, ST_S2, ST_S3, ST_S4}) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    // Status outputs; clr takes priority over count and error updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_done <= 1'b0;
            ok_count <= '0;
            err      <= 1'b0;
            err_code <= '0;
        end else begin
            seq_done <= done_n;
            if (clr) begin
                ok_count <= '0;
                err      <= 1'b0;
                err_code <= '0;
            end else begin
                if (seq_done && ok_count != 4'd15) begin
                    ok_count <= ok_count + 4'd1;
                end
                if (err_evt) begin
                    err <= 1'b1;
                    if (!err) begin
                        err_code <= err_val;
                    end
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_enable_monitor.sv
// Directed test of enable_monitor with default parameters
// (STABLE_CYC=2, TIMEOUT=200).
module tb_enable_monitor;

    logic       clk;
    logic       rst_n;
    logic [3:0] ena_in;
    logic       clr;
    logic       seq_done;
    logic [3:0] ok_count;
    logic       err;
    logic [2:0] err_code;
    logic       busy;

    int total;
    int bad;
    int done_cnt;

    enable_monitor #(
        .STABLE_CYC (2),
        .TIMEOUT    (200)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena_in   (ena_in),
        .clr      (clr),
        .seq_done (seq_done),
        .ok_count (ok_count),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count seq_done pulses, sampled away from the active edge.
    initial done_cnt = 0;
    always @(negedge clk) begin
        if (seq_done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] p, input int n);
        ena_in = p;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic legal_seq(input int h);
        hold(4'b1111, h);
        hold(4'b1110, h);
        hold(4'b1100, h);
        hold(4'b1000, h);
        hold(4'b0000, h);
    endtask

    initial begin
        int d0;
        int cyc;
        int busy_seen;
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        ena_in = 4'b0000;
        clr    = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_seq_done", int'(seq_done), 0);
        check("rst_ok_count", int'(ok_count), 0);
        check("rst_err",      int'(err),      0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_busy",     int'(busy),     0);
        rst_n = 1'b1;
        hold(4'b0000, 5);

        // Legal sequence, 10 cycles per step
        d0 = done_cnt;
        hold(4'b1111, 10);
        check("legal_busy_mid", int'(busy), 1);
        hold(4'b1110, 10);
        hold(4'b1100, 10);
        hold(4'b1000, 10);
        hold(4'b0000, 10);
        @(negedge clk);
        check("legal_pulses",   done_cnt - d0,  1);
        check("legal_ok_count", int'(ok_count), 1);
        check("legal_err",      int'(err),      0);
        check("legal_busy_end", int'(busy),     0);

        // Skipped step 1111 -> 1100
        d0 = done_cnt;
        hold(4'b1111, 10);
        hold(4'b1100, 10);
        @(negedge clk);
        check("skip_err",      int'(err),      1);
        check("skip_err_code", int'(err_code), 1);
        check("skip_busy",     int'(busy),     1);
        hold(4'b1110, 10);
        @(negedge clk);
        check("skip_busy_wait", int'(busy), 1);
        hold(4'b0000, 10);
        @(negedge clk);
        check("skip_busy_idle", int'(busy),     0);
        check("skip_no_pulse",  done_cnt - d0,  0);
        check("skip_code_kept", int'(err_code), 1);

        // clr zeroes counters and error, FSM unaffected
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
        @(negedge clk);
        check("clr_err",      int'(err),      0);
        check("clr_err_code", int'(err_code), 0);
        check("clr_ok_count", int'(ok_count), 0);

        // One-cycle glitch in IDLE is filtered out
        busy_seen = 0;
        ena_in = 4'b1111;
        @(posedge clk);
        #2;
        ena_in = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen = 1;
        end
        check("glitch_busy_seen", busy_seen,  0);
        check("glitch_busy",      int'(busy), 0);
        check("glitch_err",       int'(err),  0);

        // Timeout after 200 cycles in S1
        ena_in = 4'b1111;
        cyc = 0;
        while (busy !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        check("tmo_enter_s1", int'(busy), 1);
        cyc = 0;
        while (err !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        check("tmo_cycles",   cyc,            200);
        check("tmo_err_code", int'(err_code), 7);
        hold(4'b1111, 50);
        @(negedge clk);
        check("tmo_busy_wait", int'(busy),     1);
        check("tmo_code_kept", int'(err_code), 7);
        hold(4'b0000, 10);
        @(negedge clk);
        check("tmo_busy_idle", int'(busy), 0);
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;

        // Saturation: 17 legal sequences give ok_count=15
        d0 = done_cnt;
        for (int s = 0; s < 17; s++) legal_seq(8);
        @(negedge clk);
        check("sat_pulses",   done_cnt - d0,  17);
        check("sat_ok_count", int'(ok_count), 15);
        check("sat_err",      int'(err),      0);

        // 18th sequence: clr during its seq_done cycle
        hold(4'b1111, 8);
        hold(4'b1110, 8);
        hold(4'b1100, 8);
        hold(4'b1000, 8);
        ena_in = 4'b0000;
        cyc = 0;
        @(negedge clk);
        while (seq_done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc = cyc + 1;
        end
        check("sat18_pulse_seen", int'(seq_done), 1);
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("sat18_clr_ok_count", int'(ok_count), 0);

        // Reset pulse in S3
        legal_seq(10);
        hold(4'b1111, 10);
        hold(4'b1110, 10);
        hold(4'b1100, 10);
        @(negedge clk);
        check("s3_busy_before",  int'(busy),     1);
        check("s3_ok_before",    int'(ok_count), 1);
        #2;
        rst_n  = 1'b0;
        ena_in = 4'b0000;
        #1;
        check("s3rst_busy",     int'(busy),     0);
        check("s3rst_ok_count", int'(ok_count), 0);
        check("s3rst_err",      int'(err),      0);
        check("s3rst_seq_done", int'(seq_done), 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        d0 = done_cnt;
        hold(4'b0000, 5);
        legal_seq(10);
        @(negedge clk);
        check("after_rst_pulses", done_cnt - d0,  1);
        check("after_rst_ok",     int'(ok_count), 1);
        check("after_rst_err",    int'(err),      0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enable_monitor.md
ENABLE_MONITOR -- requirements
Module: enable_monitor

Interface
REQ-001 Parameter: STABLE_CYC, default 2, consecutive cycles a synchronized pattern must hold before acceptance (range 1..15).
REQ-002 Parameter: TIMEOUT, default 200, maximum cycles in any non-idle state without advancing (range 2..255).
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena_in  input  4  enables from enable_control, asynchronous to clk: bit0=ena_2, bit1=ena_3, bit2=ena_4, bit3=ena_5.
REQ-006 clr  input  1  synchronous clear of ok_count, err and err_code.
REQ-007 seq_done  output  1  one-cycle pulse on each completed legal sequence.
REQ-008 ok_count  output  4  completed-sequence count, saturating.
REQ-009 err  output  1  sticky error flag.
REQ-010 err_code  output  3  state index at first error since the last clear; 3'b111 = timeout.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Each ena_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Accepted pattern SHALL update only after the synchronized 4-bit value has been identical for STABLE_CYC consecutive cycles; shorter-lived values are discarded.
REQ-014 FSM states: IDLE(0), S1(1), S2(2), S3(3), S4(4), WAIT_IDLE(5).
REQ-015 Expected patterns: IDLE=4'b0000, S1=4'b1111, S2=4'b1110, S3=4'b1100, S4=4'b1000.
REQ-016 On a new accepted pattern: equal to the current state's pattern -> stay; equal to the next state's pattern -> advance (IDLE->S1->S2->S3->S4->IDLE); otherwise -> error.
REQ-017 S4->IDLE SHALL assert seq_done for exactly one cycle, registered in the same cycle the state becomes IDLE.
REQ-018 ok_count SHALL increment on seq_done and saturate at 15.
REQ-019 Error: set err; load err_code with the current state index only if err was 0; go to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL go to IDLE on the first accepted 4'b0000 without asserting seq_done.
REQ-021 Timeout counter SHALL reset on every state change and count in S1..S4; on reaching TIMEOUT, raise an error with code 3'b111.
REQ-022 The timeout counter SHALL NOT run in IDLE or WAIT_IDLE.
REQ-023 clr SHALL zero ok_count, err and err_code next cycle; clr wins over a simultaneous increment or error; FSM unaffected.
REQ-024 Latency from a stable ena_in change to the state update SHALL be 2+STABLE_CYC cycles, +1 for sampling uncertainty.

Reset
REQ-025 rst_n low SHALL immediately set synchronizers to 0, accepted pattern 4'b0000, state IDLE, stability and timeout counters 0, and all outputs 0.
REQ-026 Reset asserted mid-sequence SHALL abandon the sequence without seq_done or err.
REQ-027 After release, the first accepted pattern is evaluated from IDLE.

Structure
REQ-028 Package enable_monitor_pkg SHALL hold state encoding, the five pattern constants and the timeout error code.
REQ-029 Sub-module sync_filter SHALL implement the synchronizers and stability filter (REQ-012/013), instantiated once at width 4.
REQ-030 FSM, counters and error logic SHALL reside in enable_monitor.

Verification
REQ-031 Legal sequence 0000->1111->1110->1100->1000->0000, each held 10 cycles -> one seq_done pulse, ok_count=1, err=0.
REQ-032 Skip step 1111->1100 -> err=1, err_code=3'b001, busy stays 1 until 0000 is accepted, no seq_done.
REQ-033 Hold 1111 for 250 cycles (TIMEOUT=200) -> err=1, err_code=3'b111 at cycle 200 after entering S1.
REQ-034 1-cycle glitch 1111 inside IDLE (STABLE_CYC=2) -> no state change, busy=0, err=0.
REQ-035 17 legal sequences -> ok_count=15; then clr in the seq_done cycle of an 18th sequence -> ok_count=0.
REQ-036 rst_n pulse while in S3 -> all outputs 0 immediately; a following legal sequence gives ok_count=1.
